// File: rtl/qracc_pkg.sv
// rtl/qracc_pkg.sv - shared types for the bit-serial ADC accumulator
package qracc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } acc_state_e;

  localparam int unsigned CFG_NBITS_W = 8;

  typedef struct packed {
    logic [CFG_NBITS_W-1:0] n_bits;
    logic                   is_signed;
  } start_cfg_t;

  // A start is only meaningful for 1..max_bits bit-planes.
  function automatic logic nbits_legal(input logic [CFG_NBITS_W-1:0] n,
                                       input int unsigned max_bits);
    return (n != '0) && (32'(n) <= max_bits);
  endfunction

endpackage

// File: rtl/qracc_acc_lane.sv
// rtl/qracc_acc_lane.sv - one column shift-add accumulator register
module qracc_acc_lane
  import qracc_pkg::*;
#(
  parameter int numAdcBits = 4,
  parameter int accBits    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_i,
  input  logic                  en_i,
  input  logic                  neg_i,
  input  logic [numAdcBits-1:0] adc_i,
  output logic [accBits-1:0]    acc_o
);

  logic signed [accBits-1:0] acc_q;
  logic signed [accBits-1:0] acc_d;
  logic signed [accBits-1:0] p_ext;

  always_comb begin
    p_ext = {{(accBits-numAdcBits){adc_i[numAdcBits-1]}}, adc_i};
    acc_d = (acc_q <<< 1) + (neg_i ? -p_ext : p_ext);
  end

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      acc_q <= '0;
    end else if (en_i) begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/bitserial_accumulator.sv
// rtl/bitserial_accumulator.sv - MSB-first bit-plane accumulator over ADC columns
module bitserial_accumulator
  import qracc_pkg::*;
#(
  parameter int numCols    = 32,
  parameter int numAdcBits = 4,
  parameter int maxInBits  = 8,
  parameter int accBits    = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start_i,
  input  logic [$clog2(maxInBits):0]     n_bits_i,
  input  logic                           signed_i,
  input  logic [numCols*numAdcBits-1:0]  adc_i,
  input  logic                           adc_valid_i,
  output logic                           in_ready_o,
  output logic                           busy_o,
  output logic [numCols*accBits-1:0]     acc_o,
  output logic                           out_valid_o,
  input  logic                           out_ready_i
);

  localparam int NBW = $clog2(maxInBits) + 1;

  if (accBits < numAdcBits + maxInBits + 1) begin : g_acc_width_chk
    $error("accBits too narrow for exact accumulation");
  end
  if (NBW > int'(CFG_NBITS_W)) begin : g_cfg_width_chk
    $error("n_bits field of start_cfg_t too narrow for maxInBits");
  end

  acc_state_e     state_q, state_d;
  start_cfg_t     cfg_q, cfg_d;
  logic [NBW-1:0] cnt_q, cnt_d;

  logic start_fire;
  logic beat;
  logic last_beat;
  logic lane_clr;
  logic lane_neg;

  assign start_fire = (state_q == ST_IDLE) && start_i &&
                      nbits_legal(CFG_NBITS_W'(n_bits_i), maxInBits);
  assign beat       = (state_q == ST_ACCUM) && adc_valid_i;
  assign last_beat  = beat && (CFG_NBITS_W'(cnt_q) == cfg_q.n_bits - CFG_NBITS_W'(1));
  assign lane_clr   = start_fire;
  // The MSB plane of a two's-complement activation carries negative weight.
  assign lane_neg   = cfg_q.is_signed && (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cfg_d   = cfg_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start_fire) begin
          cfg_d.n_bits    = CFG_NBITS_W'(n_bits_i);
          cfg_d.is_signed = signed_i;
          cnt_d           = '0;
          state_d         = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (beat) begin
          cnt_d = cnt_q + NBW'(1);
          if (last_beat) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (out_ready_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cfg_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      cnt_q   <= cnt_d;
    end
  end

  for (genvar g = 0; g < numCols; g++) begin : g_lane
    qracc_acc_lane #(
      .numAdcBits(numAdcBits),
      .accBits   (accBits)
    ) u_lane (
      .clk  (clk),
      .rst  (rst),
      .clr_i(lane_clr),
      .en_i (beat),
      .neg_i(lane_neg),
      .adc_i(adc_i[g*numAdcBits +: numAdcBits]),
      .acc_o(acc_o[g*accBits +: accBits])
    );
  end

  assign in_ready_o  = (state_q == ST_ACCUM);
  assign busy_o      = (state_q != ST_IDLE);
  assign out_valid_o = (state_q == ST_DONE);

endmodule

// File: tb/tb_bitserial_accumulator.sv
// tb/tb_bitserial_accumulator.sv - randomized self-checking bench for bitserial_accumulator
module tb_bitserial_accumulator;

  localparam int NC  = 32;
  localparam int AB  = 4;
  localparam int MB  = 8;
  localparam int ACC = 16;
  localparam int NBW = $clog2(MB) + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              start_i;
  logic [NBW-1:0]    n_bits_i;
  logic              signed_i;
  logic [NC*AB-1:0]  adc_i;
  logic              adc_valid_i;
  logic              in_ready_o;
  logic              busy_o;
  logic [NC*ACC-1:0] acc_o;
  logic              out_valid_o;
  logic              out_ready_i;

  int total = 0;
  int bad   = 0;
  int pl  [MB][NC];
  int expv[NC];

  bitserial_accumulator #(
    .numCols(NC), .numAdcBits(AB), .maxInBits(MB), .accBits(ACC)
  ) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .n_bits_i(n_bits_i),
    .signed_i(signed_i), .adc_i(adc_i), .adc_valid_i(adc_valid_i),
    .in_ready_o(in_ready_o), .busy_o(busy_o), .acc_o(acc_o),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int lane_val(input int c);
    logic signed [ACC-1:0] v;
    v = acc_o[c*ACC +: ACC];
    return int'(v);
  endfunction

  task automatic drive_plane(input int b);
    for (int c = 0; c < NC; c++) adc_i[c*AB +: AB] = pl[b][c][AB-1:0];
  endtask

  task automatic rand_planes();
    for (int b = 0; b < MB; b++)
      for (int c = 0; c < NC; c++) pl[b][c] = $urandom_range(15) - 8;
  endtask

  // Reference: weighted sum of bit-planes, MSB weight negative in signed mode.
  task automatic model(input int n, input bit s);
    for (int c = 0; c < NC; c++) begin
      expv[c] = 0;
      for (int b = 0; b < n; b++) begin
        int w;
        w = 1 << (n - 1 - b);
        if (s && b == 0) w = -w;
        expv[c] += w * pl[b][c];
      end
    end
  endtask

  task automatic check_lanes(input string tag);
    for (int c = 0; c < NC; c++) begin
      total++;
      if (lane_val(c) !== expv[c]) begin
        bad++;
        $display("FAIL %s lane %0d: got %0d want %0d", tag, c, lane_val(c), expv[c]);
      end
    end
  endtask

  task automatic accumulate(input int n, input bit s, input bit gaps, input bit handshake);
    start_i = 1'b1; n_bits_i = NBW'(n); signed_i = s;
    tick();
    start_i = 1'b0; signed_i = $urandom_range(1);
    total++;
    if (in_ready_o !== 1'b1 || busy_o !== 1'b1 || lane_val(0) !== 0) begin
      bad++;
      $display("FAIL start: in_ready=%0b busy=%0b lane0=%0d want 1 1 0", in_ready_o, busy_o, lane_val(0));
    end
    for (int b = 0; b < n; b++) begin
      if (gaps) begin
        int g;
        g = $urandom_range(2);
        for (int k = 0; k < g; k++) begin
          adc_i = {$urandom, $urandom, $urandom, $urandom};
          tick();
        end
      end
      drive_plane(b);
      adc_valid_i = 1'b1;
      tick();
      adc_valid_i = 1'b0;
      total++;
      if (out_valid_o !== (b == n - 1)) begin
        bad++;
        $display("FAIL latency beat %0d: out_valid=%0b want %0b", b, out_valid_o, b == n - 1);
      end
    end
    model(n, s);
    check_lanes("accum");
    if (handshake) begin
      out_ready_i = 1'b1;
      tick();
      out_ready_i = 1'b0;
      total++;
      if (busy_o !== 1'b0 || out_valid_o !== 1'b0) begin
        bad++;
        $display("FAIL handshake: busy=%0b out_valid=%0b want 0 0", busy_o, out_valid_o);
      end
      check_lanes("hold_idle");
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start_i = 0; n_bits_i = 0; signed_i = 0; adc_i = '0;
    adc_valid_i = 0; out_ready_i = 0;
    tick(); tick();
    rst = 1'b0;
    total++;
    if (acc_o !== '0 || out_valid_o !== 0 || in_ready_o !== 0 || busy_o !== 0) begin
      bad++;
      $display("FAIL reset: acc_nz=%0b ov=%0b ir=%0b busy=%0b want all 0", |acc_o, out_valid_o, in_ready_o, busy_o);
    end
  endtask

  task automatic test_directed();
    for (int b = 0; b < MB; b++) for (int c = 0; c < NC; c++) pl[b][c] = 0;
    pl[0][0] = 1; pl[3][0] = 1;
    accumulate(4, 0, 0, 1);
    total++; if (lane_val(0) !== 9) begin bad++; $display("FAIL unsigned_9: got %0d want 9", lane_val(0)); end
    accumulate(4, 1, 1, 1);
    total++; if (lane_val(0) !== -7) begin bad++; $display("FAIL signed_m7: got %0d want -7", lane_val(0)); end
    for (int b = 0; b < MB; b++) for (int c = 0; c < NC; c++) pl[b][c] = -8;
    accumulate(8, 0, 0, 1);
    total++; if (lane_val(NC-1) !== -2040) begin bad++; $display("FAIL unsigned_m8: got %0d want -2040", lane_val(NC-1)); end
    accumulate(8, 1, 0, 1);
    total++; if (lane_val(5) !== 8) begin bad++; $display("FAIL signed_m8: got %0d want 8", lane_val(5)); end
    for (int b = 0; b < MB; b++) for (int c = 0; c < NC; c++) pl[b][c] = 7;
    accumulate(8, 0, 1, 1);
    total++; if (lane_val(17) !== 1785) begin bad++; $display("FAIL unsigned_7: got %0d want 1785", lane_val(17)); end
  endtask

  task automatic test_backpressure();
    rand_planes();
    accumulate(5, 1, 1, 0);
    for (int k = 0; k < 3; k++) begin
      adc_i = {$urandom, $urandom, $urandom, $urandom};
      adc_valid_i = 1'b1; start_i = 1'b1; n_bits_i = 1;
      tick();
      total++;
      if (out_valid_o !== 1'b1 || in_ready_o !== 1'b0) begin
        bad++;
        $display("FAIL backpressure: out_valid=%0b in_ready=%0b want 1 0", out_valid_o, in_ready_o);
      end
      check_lanes("bp_stable");
    end
    adc_valid_i = 1'b0;
    out_ready_i = 1'b1; start_i = 1'b1; n_bits_i = 2;
    tick();
    out_ready_i = 1'b0; start_i = 1'b0;
    tick();
    total++;
    if (busy_o !== 1'b0 || out_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL start_at_handshake: busy=%0b out_valid=%0b want 0 0", busy_o, out_valid_o);
    end
    check_lanes("bp_after");
  endtask

  task automatic test_reset_mid();
    rand_planes();
    start_i = 1'b1; n_bits_i = 4; signed_i = 0;
    tick();
    start_i = 1'b0;
    for (int b = 0; b < 2; b++) begin drive_plane(b); adc_valid_i = 1'b1; tick(); end
    adc_valid_i = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if (acc_o !== '0 || out_valid_o !== 0 || in_ready_o !== 0 || busy_o !== 0) begin
      bad++;
      $display("FAIL reset_mid: acc_nz=%0b ov=%0b ir=%0b busy=%0b want all 0", |acc_o, out_valid_o, in_ready_o, busy_o);
    end
    for (int k = 0; k < 4; k++) begin
      drive_plane(k); adc_valid_i = 1'b1;
      tick();
      total++;
      if (out_valid_o !== 1'b0 || busy_o !== 1'b0) begin
        bad++;
        $display("FAIL reset_no_present: out_valid=%0b busy=%0b want 0 0", out_valid_o, busy_o);
      end
    end
    adc_valid_i = 1'b0;
    pl[0][0] = 5;
    accumulate(1, 0, 0, 1);
    total++; if (lane_val(0) !== 5) begin bad++; $display("FAIL reset_fresh: got %0d want 5", lane_val(0)); end
  endtask

  task automatic test_bad_start();
    for (int i = 0; i < 2; i++) begin
      start_i = 1'b1; n_bits_i = (i == 0) ? NBW'(0) : NBW'(MB + 1 + $urandom_range(6));
      tick();
      start_i = 1'b0;
      adc_i = {$urandom, $urandom, $urandom, $urandom}; adc_valid_i = 1'b1;
      tick();
      adc_valid_i = 1'b0;
      total++;
      if (busy_o !== 1'b0 || out_valid_o !== 1'b0 || in_ready_o !== 1'b0) begin
        bad++;
        $display("FAIL bad_start n=%0d: busy=%0b out_valid=%0b in_ready=%0b want 0 0 0", n_bits_i, busy_o, out_valid_o, in_ready_o);
      end
      check_lanes("bad_start_hold");
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 20; it++) begin
      rand_planes();
      accumulate($urandom_range(MB, 1), $urandom_range(1), 1, 1);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_bad_start();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
